// File: rtl/puf_resp_serializer_if.sv
// SPI master byte channel between the PUF response serializer (master side,
// which offers bytes) and the SPI master (slave side, which consumes them).
interface puf_resp_serializer_if;
  logic [7:0] o_TX_Byte;
  logic       o_TX_DV;
  logic       i_TX_Ready;

  modport master (
    output o_TX_Byte,
    output o_TX_DV,
    input  i_TX_Ready
  );

  modport slave (
    input  o_TX_Byte,
    input  o_TX_DV,
    output i_TX_Ready
  );
endinterface

// File: rtl/puf_resp_serializer.sv
// PUF response serializer: latches a completed RO-PUF response on the done
// pulse and streams it to the SPI master as HEADER, response bytes (MSB
// first) and, optionally, an XOR checksum byte. A rejected response is sent
// as the single REJECT_BYTE.
// Optional feature macro: RESP_CHECKSUM_EN (appends the XOR checksum byte).
module puf_resp_serializer #(
  parameter int         RESP_WIDTH  = 256,
  parameter logic [7:0] HEADER_BYTE = 8'hA5,
  parameter logic [7:0] REJECT_BYTE = 8'hAA
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      i_load,
  input  logic [RESP_WIDTH-1:0]     i_response,
  input  logic                      i_valid,
  input  logic                      i_abort,
  puf_resp_serializer_if.master     tx,
  output logic                      o_busy,
  output logic                      o_done
);

  localparam logic [5:0] NBYTES = 6'(RESP_WIDTH / 8);
`ifdef RESP_CHECKSUM_EN
  localparam logic [5:0] VALID_LEN = NBYTES + 6'd2;
`else
  localparam logic [5:0] VALID_LEN = NBYTES + 6'd1;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t                state_q;
  logic [RESP_WIDTH-1:0] buf_q;      // shift buffer, next response byte on top
  logic                  valid_q;
  logic [5:0]            idx_q;
  logic [7:0]            tx_byte_q;
  logic                  tx_dv_q;
  logic                  busy_q;
  logic                  done_q;
`ifdef RESP_CHECKSUM_EN
  logic [7:0]            csum_q;
`endif

  logic [7:0] cur_byte_d;
  logic [5:0] frame_len_d;
  logic       data_idx_d;

  // Response bytes occupy indices 1..NBYTES of a valid frame.
  assign data_idx_d  = valid_q && (idx_q != 6'd0) && (idx_q <= NBYTES);
  assign frame_len_d = valid_q ? VALID_LEN : 6'd1;

  // Select the byte that belongs at the current frame index.
  always_comb begin
    cur_byte_d = buf_q[RESP_WIDTH-1 -: 8];
    if (!valid_q) begin
      cur_byte_d = REJECT_BYTE;
    end else if (idx_q == 6'd0) begin
      cur_byte_d = HEADER_BYTE;
`ifdef RESP_CHECKSUM_EN
    end else if (idx_q > NBYTES) begin
      cur_byte_d = csum_q;
`endif
    end
  end

  // Frame FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= ST_IDLE;
      buf_q     <= '0;
      valid_q   <= 1'b0;
      idx_q     <= 6'd0;
      tx_byte_q <= 8'h00;
      tx_dv_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef RESP_CHECKSUM_EN
      csum_q    <= 8'h00;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          // Abort wins over a simultaneous load.
          if (i_load && !i_abort) begin
            buf_q   <= i_response;
            valid_q <= i_valid;
            idx_q   <= 6'd0;
            busy_q  <= 1'b1;
`ifdef RESP_CHECKSUM_EN
            csum_q  <= 8'h00;
`endif
            state_q <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (tx.i_TX_Ready) begin
            tx_byte_q <= cur_byte_d;
            tx_dv_q   <= 1'b1;
            idx_q     <= idx_q + 6'd1;
            if (data_idx_d) begin
              buf_q  <= {buf_q[RESP_WIDTH-9:0], 8'h00};
`ifdef RESP_CHECKSUM_EN
              csum_q <= csum_q ^ buf_q[RESP_WIDTH-1 -: 8];
`endif
            end
            state_q <= ST_GAP;
          end
        end
        ST_GAP: begin
          // One dead cycle so the master can drop ready after the strobe.
          tx_dv_q <= 1'b0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (tx.i_TX_Ready) begin
            state_q <= (idx_q == frame_len_d) ? ST_DONE : ST_SEND;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase

      // Abort overrides whatever the active state scheduled; a byte that
      // was already strobed stays on the bus.
      if (i_abort && (state_q != ST_IDLE)) begin
        state_q <= ST_IDLE;
        tx_dv_q <= 1'b0;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end
    end
  end

  assign tx.o_TX_Byte = tx_byte_q;
  assign tx.o_TX_DV   = tx_dv_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;

endmodule
